// File: rtl/minicpu_mem_pkg.sv
// Shared miniCPU memory-path types and constants.
package minicpu_mem_pkg;

    localparam int unsigned MINICPU_ADDR_W = 32;
    localparam int unsigned MINICPU_DATA_W = 32;

    // First fetch address after reset.
    localparam logic [MINICPU_ADDR_W-1:0] MINICPU_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } own_e;

endpackage : minicpu_mem_pkg

// File: rtl/minicpu_sram_arb_if.sv
// Core-side request/response bus: fetch and load/store ports of the miniCPU.
interface minicpu_sram_arb_if
    import minicpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MINICPU_ADDR_W,
    parameter int unsigned DATA_W = MINICPU_DATA_W
) ();

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // Core side issues requests and consumes responses.
    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    // Arbiter side accepts requests and returns responses.
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface : minicpu_sram_arb_if

// File: rtl/minicpu_sram_arb.sv
// Fetch/data arbiter for one single-port synchronous-read SRAM.
// Data has priority; fetch is served after MAX_DATA_RUN consecutive data grants.
module minicpu_sram_arb
    import minicpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = MINICPU_ADDR_W,
    parameter int unsigned DATA_W       = MINICPU_DATA_W,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic               clk,
    input  logic               resetn,
    minicpu_sram_arb_if.slave  core,
    output logic               sram_en,
    output logic               sram_we,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata
);

    localparam int unsigned     CNT_W   = 4;
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    logic             rst_done_q;
    logic             resp_vld_q, resp_vld_d;
    logic             resp_wr_q,  resp_wr_d;
    own_e             resp_own_q, resp_own_d;
    logic [CNT_W-1:0] run_cnt_q,  run_cnt_d;
    logic             gnt_inst, gnt_data;

    // Grant: data first unless fetch has waited out a full data run.
    always_comb begin
        gnt_data = 1'b0;
        gnt_inst = 1'b0;
        if (rst_done_q) begin
            if (core.data_req && !(core.inst_req && (run_cnt_q == RUN_MAX))) begin
                gnt_data = 1'b1;
            end else if (core.inst_req) begin
                gnt_inst = 1'b1;
            end
        end
    end

    assign sram_en    = gnt_data | gnt_inst;
    assign sram_we    = gnt_data & core.data_we;
    assign sram_addr  = gnt_data ? core.data_addr : core.inst_addr;
    assign sram_wdata = gnt_data ? core.data_wdata : '0;

    assign core.inst_addr_ok = gnt_inst;
    assign core.data_addr_ok = gnt_data;

    always_comb begin
        resp_vld_d = sram_en;
        resp_wr_d  = sram_we;
        resp_own_d = OWN_NONE;
        run_cnt_d  = run_cnt_q;
        if (gnt_data) begin
            resp_own_d = OWN_DATA;
        end else if (gnt_inst) begin
            resp_own_d = OWN_INST;
        end
        if (gnt_inst || !core.inst_req) begin
            run_cnt_d = '0;
        end else if (gnt_data && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_done_q <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_wr_q  <= 1'b0;
            resp_own_q <= OWN_NONE;
            run_cnt_q  <= '0;
        end else begin
            rst_done_q <= 1'b1;
            resp_vld_q <= resp_vld_d;
            resp_wr_q  <= resp_wr_d;
            resp_own_q <= resp_own_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    // Route the one-cycle-late SRAM response to whichever port was granted.
    assign core.inst_data_ok = resp_vld_q && (resp_own_q == OWN_INST);
    assign core.data_data_ok = resp_vld_q && (resp_own_q == OWN_DATA);
    assign core.inst_rdata   = (core.inst_data_ok && !resp_wr_q) ? sram_rdata : '0;
    assign core.data_rdata   = (core.data_data_ok && !resp_wr_q) ? sram_rdata : '0;

endmodule : minicpu_sram_arb
